next_pc_predictor: RTL and testbench

NEXT_PC_PREDICTOR -- requirements
Module: next_pc_predictor

---
 rtl/next_pc_predictor_pkg.sv | 22 ++
 rtl/next_pc_predictor_btb_table.sv | 52 +++++
 rtl/next_pc_predictor.sv | 120 ++++++++++++
 tb/tb_next_pc_predictor.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/next_pc_predictor_pkg.sv
// rtl/next_pc_predictor_pkg.sv - shared FSM states and 2-bit counter constants for the next-PC predictor
package next_pc_predictor_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/next_pc_predictor_btb_table.sv
// rtl/next_pc_predictor_btb_table.sv - branch target table, combinational reads, one synchronous write port
module btb_table #(
    parameter int DBITS = 16,
    parameter int IBITS = 6,
    parameter int TBITS = DBITS - IBITS - 1
) (
    input  logic             clk,
    input  logic [IBITS-1:0] lk_idx,
    output logic             lk_valid,
    output logic [TBITS-1:0] lk_tag,
    output logic [DBITS-1:0] lk_target,
    output logic [1:0]       lk_ctr,
    input  logic [IBITS-1:0] up_idx,
    output logic             up_valid,
    output logic [TBITS-1:0] up_tag,
    output logic [1:0]       up_ctr,
    input  logic             we_meta,
    input  logic             we_data,
    input  logic [IBITS-1:0] wr_idx,
    input  logic             wr_valid,
    input  logic [1:0]       wr_ctr,
    input  logic [TBITS-1:0] wr_tag,
    input  logic [DBITS-1:0] wr_target
);
    localparam int ENTRIES = 1 << IBITS;

    // No reset here: valid/counter are cleared by the init sweep, tag/target are don't-care until valid.
    logic             valid_q  [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [TBITS-1:0] tag_q    [ENTRIES];
    logic [DBITS-1:0] target_q [ENTRIES];

    assign lk_valid  = valid_q[lk_idx];
    assign lk_tag    = tag_q[lk_idx];
    assign lk_target = target_q[lk_idx];
    assign lk_ctr    = ctr_q[lk_idx];
    assign up_valid  = valid_q[up_idx];
    assign up_tag    = tag_q[up_idx];
    assign up_ctr    = ctr_q[up_idx];

    always_ff @(posedge clk) begin
        if (we_meta) begin
            valid_q[wr_idx] <= wr_valid;
            ctr_q[wr_idx]   <= wr_ctr;
        end
        if (we_data) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/next_pc_predictor.sv
// rtl/next_pc_predictor.sv - fetch PC register with BTB-based next-PC prediction and init sweep
module next_pc_predictor
    import next_pc_predictor_pkg::*;
#(
    parameter int               DBITS    = 16,
    parameter int               IBITS    = 6,
    parameter logic [DBITS-1:0] RESET_PC = 16'h0200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [DBITS-1:0] pc,
    output logic             busy,
    input  logic             redirect,
    input  logic [DBITS-1:0] redirect_pc,
    input  logic             upd_valid,
    input  logic [DBITS-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [DBITS-1:0] upd_target
);
    localparam int TBITS = DBITS - IBITS - 1;

    state_t           state;
    logic [IBITS-1:0] init_idx;

    logic             lk_valid, up_valid;
    logic [TBITS-1:0] lk_tag, up_tag;
    logic [DBITS-1:0] lk_target;
    logic [1:0]       lk_ctr, up_ctr;

    logic             we_meta, we_data, wr_valid;
    logic [IBITS-1:0] wr_idx;
    logic [1:0]       wr_ctr;

    logic             hit, upd_match;
    logic [DBITS-1:0] next_pc;
    logic             unused_bits;

    // Bit 0 of the branch PC carries no information with 2-byte aligned instructions.
    assign unused_bits = upd_pc[0];

    assign hit       = lk_valid && (lk_tag == pc[DBITS-1:IBITS+1]) && lk_ctr[1];
    assign next_pc   = hit ? lk_target : pc + DBITS'(2);
    assign upd_match = up_valid && (up_tag == upd_pc[DBITS-1:IBITS+1]);

    btb_table #(
        .DBITS(DBITS),
        .IBITS(IBITS)
    ) u_table (
        .clk       (clk),
        .lk_idx    (pc[IBITS:1]),
        .lk_valid  (lk_valid),
        .lk_tag    (lk_tag),
        .lk_target (lk_target),
        .lk_ctr    (lk_ctr),
        .up_idx    (upd_pc[IBITS:1]),
        .up_valid  (up_valid),
        .up_tag    (up_tag),
        .up_ctr    (up_ctr),
        .we_meta   (we_meta),
        .we_data   (we_data),
        .wr_idx    (wr_idx),
        .wr_valid  (wr_valid),
        .wr_ctr    (wr_ctr),
        .wr_tag    (upd_pc[DBITS-1:IBITS+1]),
        .wr_target (upd_target)
    );

    always_comb begin
        we_meta  = 1'b0;
        we_data  = 1'b0;
        wr_idx   = upd_pc[IBITS:1];
        wr_valid = 1'b0;
        wr_ctr   = CTR_SNT;
        if (!reset && state == INIT) begin
            we_meta = 1'b1;
            wr_idx  = init_idx;
        end else if (!reset && state == RUN && upd_valid) begin
            if (upd_taken) begin
                we_meta  = 1'b1;
                we_data  = 1'b1;
                wr_valid = 1'b1;
                wr_ctr   = upd_match ? ctr_inc(up_ctr) : CTR_WT;
            end else if (upd_match) begin
                // Not-taken on a foreign or empty entry leaves it untouched.
                we_meta  = 1'b1;
                wr_valid = 1'b1;
                wr_ctr   = ctr_dec(up_ctr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            init_idx <= '0;
            pc       <= RESET_PC;
            busy     <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (&init_idx) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (en) begin
                        pc <= next_pc;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_next_pc_predictor.sv
// tb/tb_next_pc_predictor.sv - self-checking bench for next_pc_predictor with a behavioural table model
module tb_next_pc_predictor;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0, en = 1'b0, redirect = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0;
    logic [15:0] redirect_pc = '0, upd_pc = '0, upd_target = '0;
    logic [15:0] pc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bit m_valid [N];
    int m_tag   [N];
    int m_target[N];
    int m_ctr   [N];
    int m_pc = 0;
    int init_left = 0;
    bit model_ok = 1'b0;

    next_pc_predictor #(.DBITS(16), .IBITS(4), .RESET_PC(16'h0200)) dut (
        .clk(clk), .reset(reset), .en(en), .pc(pc), .busy(busy),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
    );

    always #5 clk = ~clk;

    // Reference: what the fetch PC and table must become, from the rules in plain arithmetic.
    always @(posedge clk) begin
        int li, ui, nxt;
        bit hit, match;
        if (reset) begin
            init_left = N;
            m_pc = 'h200;
            model_ok = 1'b1;
        end else if (init_left > 0) begin
            m_valid[N - init_left] = 1'b0;
            m_ctr[N - init_left] = 0;
            init_left--;
        end else begin
            li  = (m_pc / 2) % N;
            hit = m_valid[li] && (m_tag[li] == m_pc / 32) && (m_ctr[li] >= 2);
            nxt = hit ? m_target[li] : (m_pc + 2) % 65536;
            if (upd_valid) begin
                ui = (int'(upd_pc) / 2) % N;
                match = m_valid[ui] && (m_tag[ui] == int'(upd_pc) / 32);
                if (upd_taken) begin
                    m_ctr[ui]    = match ? ((m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1) : 2;
                    m_valid[ui]  = 1'b1;
                    m_tag[ui]    = int'(upd_pc) / 32;
                    m_target[ui] = int'(upd_target);
                end else if (match && m_ctr[ui] > 0) begin
                    m_ctr[ui] = m_ctr[ui] - 1;
                end
            end
            if (redirect) m_pc = int'(redirect_pc);
            else if (en)  m_pc = nxt;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (pc !== 16'(m_pc) || busy !== (init_left > 0)) begin
                errors++;
                $display("FAIL cycle_check t=%0t pc=%h busy=%b expected pc=%h busy=%b",
                         $time, pc, busy, 16'(m_pc), (init_left > 0));
            end
        end
    end

    task automatic cyc(input bit e, input bit r, input logic [15:0] rp,
                       input bit uv, input logic [15:0] up, input bit ut, input logic [15:0] tg);
        en = e; redirect = r; redirect_pc = rp;
        upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = tg;
        @(posedge clk);
        #1;
    endtask

    task automatic adv();
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic expect16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        expect16("busy_after_reset", 16'(busy), 16'h1);
        expect16("pc_after_reset", pc, 16'h0200);
        // Init sweep: redirect, en and a taken update on the final cycle must all be ignored.
        for (int i = 0; i < N; i++) begin
            cyc(1'b1, 1'b1, 16'h0400, (i == N - 1), 16'h0200, 1'b1, 16'h0500);
            expect16("init_busy", 16'(busy), (i < N - 1) ? 16'h1 : 16'h0);
            expect16("init_pc", pc, 16'h0200);
        end
        adv(); expect16("seq_0202", pc, 16'h0202);
        adv(); expect16("seq_0204", pc, 16'h0204);

        cyc(1'b0, 1'b0, 16'h0, 1'b1, 16'h0204, 1'b1, 16'h0300);
        expect16("hold_en0", pc, 16'h0204);
        adv(); expect16("hit_ctr2", pc, 16'h0300);

        cyc(1'b0, 1'b1, 16'h0204, 1'b1, 16'h0204, 1'b0, 16'h0);
        expect16("redirect_with_update", pc, 16'h0204);
        adv(); expect16("miss_ctr1", pc, 16'h0206);

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'h0204, 1'b1, 16'h0204, 1'b1, 16'h0300);
        adv(); expect16("hit_ctr3", pc, 16'h0300);
        cyc(1'b0, 1'b1, 16'h0204, 1'b1, 16'h0204, 1'b0, 16'h0);
        adv(); expect16("saturated_then_dec", pc, 16'h0300);
        cyc(1'b0, 1'b1, 16'h0204, 1'b1, 16'h0204, 1'b0, 16'h0);
        adv(); expect16("dec_to_ctr1", pc, 16'h0206);

        cyc(1'b0, 1'b1, 16'h0224, 1'b1, 16'h0204, 1'b1, 16'h0300);
        adv(); expect16("alias_miss", pc, 16'h0226);
        cyc(1'b0, 1'b1, 16'h0204, 1'b1, 16'h0224, 1'b0, 16'h0);
        adv(); expect16("alias_nt_no_change", pc, 16'h0300);

        cyc(1'b0, 1'b1, 16'h0400, 1'b0, 16'h0, 1'b0, 16'h0);
        expect16("redirect_en0", pc, 16'h0400);

        cyc(1'b0, 1'b1, 16'h0210, 1'b0, 16'h0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 16'h0, 1'b1, 16'h0210, 1'b1, 16'h0600);
        expect16("same_cycle_old_view", pc, 16'h0212);
        cyc(1'b0, 1'b1, 16'h0210, 1'b0, 16'h0, 1'b0, 16'h0);
        adv(); expect16("new_view_next_cycle", pc, 16'h0600);

        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                16'h0200 + 16'(2 * $urandom_range(0, 31)),
                $urandom_range(0, 2) == 0, 16'h0200 + 16'(2 * $urandom_range(0, 31)),
                $urandom_range(0, 1) == 1, 16'h0200 + 16'(2 * $urandom_range(0, 31)));
            reset = 1'b0;
        end

        // Populate 0x0204 strongly, then reset mid-run must invalidate it.
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 16'h0204, 1'b1, 16'h0204, 1'b1, 16'h0300);
        do_reset();
        for (int i = 0; i < N; i++) begin
            expect16("resweep_busy", 16'(busy), 16'h1);
            cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
        end
        expect16("resweep_done", 16'(busy), 16'h0);
        adv(); adv();
        expect16("resweep_at_0204", pc, 16'h0204);
        adv(); expect16("entry_invalidated", pc, 16'h0206);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
